// File: rtl/playback_sequencer_if.sv
// playback_sequencer_if
//   Bundles the control inputs and playback outputs of the audio playback
//   sequencer so that the sequencer and its driver connect through one port.
//
//   Signals:
//     enable      global run; low freezes the sequencer
//     trig[3:0]   level trigger per clip; a rising edge requests that clip
//     stop        abort playback and flush pending requests
//     loop        sampled at clip end; high replays the same clip
//     rom_addr    current 14-bit ROM sample address
//     sample_tick one-cycle pulse per sample period while playing
//     play_en     enable for the PWM stage
//     active_clip index of the granted clip
//     busy        high whenever the sequencer is not idle
//     clip_done   one-cycle pulse when a clip's last sample period ends
//     pending     latched, not-yet-granted requests
//
//   Modports:
//     master  drives the control inputs, observes the outputs
//     slave   the sequencer itself
interface playback_sequencer_if;
  logic        enable;
  logic [3:0]  trig;
  logic        stop;
  logic        loop;
  logic [13:0] rom_addr;
  logic        sample_tick;
  logic        play_en;
  logic [1:0]  active_clip;
  logic        busy;
  logic        clip_done;
  logic [3:0]  pending;

  modport master (
    output enable, trig, stop, loop,
    input  rom_addr, sample_tick, play_en, active_clip, busy, clip_done, pending
  );

  modport slave (
    input  enable, trig, stop, loop,
    output rom_addr, sample_tick, play_en, active_clip, busy, clip_done, pending
  );
endinterface

// File: rtl/playback_sequencer.sv
// playback_sequencer
//   Generates the ROM address stream for the audio player. A table of four
//   clips (start address, length) is fixed by parameters. Rising edges on
//   trig latch requests, which are granted lowest index first. The granted
//   clip is played one address per sample period, followed by a silent gap
//   before the next grant.
//
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset
//     bus   playback_sequencer_if.slave (enable, trig, stop, loop in;
//           rom_addr, sample_tick, play_en, active_clip, busy, clip_done,
//           pending out)
module playback_sequencer #(
  parameter int          CLOCK_RATE  = 400_000,
  parameter int          SAMPLE_RATE = 16_000,
  parameter logic [55:0] CLIP_START  = {14'd12288, 14'd8192, 14'd4096, 14'd0},
  parameter logic [55:0] CLIP_LEN    = {4{14'd4096}},
  parameter int          GAP_CYCLES  = 16
) (
  input logic                 clk,
  input logic                 rst,
  playback_sequencer_if.slave bus
);

  localparam int DIVIDER = CLOCK_RATE / SAMPLE_RATE;
  localparam int DW      = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t        state, state_next;
  logic [3:0]    trig_q, trig_rise, pending, pending_next;
  logic [1:0]    active_clip, active_next, grant_idx;
  logic [13:0]   rom_addr, addr_next, remaining, remaining_next;
  logic [DW-1:0] divider, divider_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic          tick, done, grant;

  function automatic logic [13:0] clip_start(input logic [1:0] idx);
    return CLIP_START[14*idx +: 14];
  endfunction

  // Remaining-sample count loaded at clip start; a zero length still plays
  // one sample.
  function automatic logic [13:0] clip_last(input logic [1:0] idx);
    logic [13:0] len;
    len = CLIP_LEN[14*idx +: 14];
    return (len == 14'd0) ? 14'd0 : len - 14'd1;
  endfunction

  assign trig_rise = bus.trig & ~trig_q;

  // Lowest pending index wins the grant.
  always_comb begin
    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) grant_idx = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      trig_q      <= '0;
      pending     <= '0;
      active_clip <= '0;
      rom_addr    <= '0;
      remaining   <= '0;
      divider     <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_next;
      trig_q      <= bus.trig;
      pending     <= pending_next;
      active_clip <= active_next;
      rom_addr    <= addr_next;
      remaining   <= remaining_next;
      divider     <= divider_next;
      gap_cnt     <= gap_next;
    end
  end

  // Next-state and datapath updates. Everything except request latching and
  // stop is frozen while enable is low. Request bits set after the grant
  // clear so a same-cycle re-trigger survives; stop overrides all of it.
  always_comb begin
    state_next     = state;
    pending_next   = pending;
    active_next    = active_clip;
    addr_next      = rom_addr;
    remaining_next = remaining;
    divider_next   = divider;
    gap_next       = gap_cnt;
    tick           = 1'b0;
    done           = 1'b0;
    grant          = 1'b0;

    if (bus.enable) begin
      case (state)
        IDLE: grant = |pending;
        LOAD: begin
          addr_next      = clip_start(active_clip);
          remaining_next = clip_last(active_clip);
          divider_next   = '0;
          state_next     = PLAY;
        end
        PLAY: begin
          if (divider == DIV_LAST) begin
            divider_next = '0;
            tick         = 1'b1;
            if (remaining != 14'd0) begin
              addr_next      = rom_addr + 14'd1;
              remaining_next = remaining - 14'd1;
            end else begin
              done = 1'b1;
              if (bus.loop) begin
                addr_next      = clip_start(active_clip);
                remaining_next = clip_last(active_clip);
              end else begin
                state_next = GAP;
                gap_next   = '0;
              end
            end
          end else begin
            divider_next = divider + DW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (|pending) grant = 1'b1;
            else state_next = IDLE;
          end else begin
            gap_next = gap_cnt + GW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    if (grant) begin
      active_next             = grant_idx;
      pending_next[grant_idx] = 1'b0;
      state_next              = LOAD;
    end

    pending_next = pending_next | trig_rise;

    if (bus.stop) begin
      state_next     = IDLE;
      pending_next   = '0;
      divider_next   = '0;
      active_next    = active_clip;
      addr_next      = rom_addr;
      remaining_next = remaining;
      gap_next       = gap_cnt;
      tick           = 1'b0;
      done           = 1'b0;
    end
  end

  assign bus.rom_addr    = rom_addr;
  assign bus.sample_tick = tick;
  assign bus.clip_done   = done;
  assign bus.play_en     = bus.enable && (state == PLAY);
  assign bus.active_clip = active_clip;
  assign bus.busy        = (state != IDLE);
  assign bus.pending     = pending;

endmodule

// File: tb/tb_playback_sequencer.sv
// tb_playback_sequencer
//   Self-checking bench for playback_sequencer. A behavioural model tracks,
//   per granted clip, the number of enabled cycles since the grant and
//   derives the expected address and strobes from that count arithmetically.
//   Directed scenarios cover the single-clip timeline, priority, address
//   wrap, stop, loop and enable freeze; a randomized run compares every
//   output against the model each cycle.
module tb_playback_sequencer;

  localparam int CLOCK_RATE  = 400_000;
  localparam int SAMPLE_RATE = 16_000;
  localparam int GAP         = 16;
  localparam int DIV         = CLOCK_RATE / SAMPLE_RATE;
  localparam logic [55:0] STARTS = {14'd16382, 14'd8192, 14'd4096, 14'd0};
  localparam logic [55:0] LENS   = {14'd4, 14'd0, 14'd3, 14'd4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  playback_sequencer_if bus();

  playback_sequencer #(
    .CLOCK_RATE (CLOCK_RATE),
    .SAMPLE_RATE(SAMPLE_RATE),
    .CLIP_START (STARTS),
    .CLIP_LEN   (LENS),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int ref_start[4] = '{0, 4096, 8192, 16382};
  int ref_len[4]   = '{4, 3, 0, 4};

  // Model state: whether a clip is granted, which one, and how many enabled
  // cycles have elapsed since its grant (0 = load cycle).
  bit          m_busy      = 1'b0;
  int          m_clip      = 0;
  int          m_phase     = 0;
  logic [3:0]  m_pend      = '0;
  logic [3:0]  m_trig_prev = '0;
  logic [13:0] m_addr_last = '0;

  function automatic int ticks_of(input int c);
    return (ref_len[c] == 0) ? 1 : ref_len[c];
  endfunction

  function automatic bit model_in_play();
    return m_busy && m_phase >= 1 && m_phase <= DIV * ticks_of(m_clip);
  endfunction

  function automatic logic [13:0] model_addr();
    int n;
    n = ticks_of(m_clip);
    if (model_in_play())
      return 14'((ref_start[m_clip] + (m_phase - 1) / DIV) % 16384);
    if (m_busy && m_phase > DIV * n)
      return 14'((ref_start[m_clip] + n - 1) % 16384);
    return m_addr_last;
  endfunction

  function automatic bit exp_play();
    return bus.enable && model_in_play();
  endfunction

  function automatic bit exp_tick();
    return exp_play() && !bus.stop && (m_phase % DIV == 0);
  endfunction

  function automatic bit exp_done();
    return exp_tick() && (m_phase == DIV * ticks_of(m_clip));
  endfunction

  // Model update on each clock edge using the inputs held during the cycle.
  always @(posedge clk) begin : model
    logic [3:0] rise;
    bit         grant;
    int         p_end;
    if (rst) begin
      m_busy = 1'b0; m_clip = 0; m_phase = 0;
      m_pend = '0; m_trig_prev = '0; m_addr_last = '0;
    end else begin
      rise        = bus.trig & ~m_trig_prev;
      m_trig_prev = bus.trig;
      m_addr_last = model_addr();
      grant       = 1'b0;
      if (bus.stop) begin
        m_busy = 1'b0;
        m_pend = '0;
      end else begin
        if (bus.enable) begin
          if (!m_busy) begin
            grant = (m_pend != 4'b0000);
          end else begin
            p_end = DIV * ticks_of(m_clip);
            if (m_phase == p_end && bus.loop) m_phase = 1;
            else if (m_phase == p_end + GAP) begin
              if (m_pend != 4'b0000) grant = 1'b1;
              else m_busy = 1'b0;
            end else m_phase++;
          end
        end
        if (grant) begin
          for (int i = 3; i >= 0; i--) if (m_pend[i]) m_clip = i;
          m_pend[m_clip] = 1'b0;
          m_busy  = 1'b1;
          m_phase = 0;
        end
        m_pend = m_pend | rise;
      end
    end
  end

  // Advance one clock and land on the falling edge for observation.
  task automatic tick_clk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.enable = 1'b1; bus.trig = '0; bus.stop = 1'b0; bus.loop = 1'b0;
    rst = 1'b1;
    repeat (3) tick_clk();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      checks++;
      if ({bus.rom_addr, bus.sample_tick, bus.play_en, bus.active_clip,
           bus.busy, bus.clip_done, bus.pending} !== 25'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: addr=%0d tick=%b play=%b clip=%0d busy=%b done=%b pend=%b, expected all zero",
                 i, bus.rom_addr, bus.sample_tick, bus.play_en, bus.active_clip,
                 bus.busy, bus.clip_done, bus.pending);
      end
    end
  endtask

  task automatic test_single_clip();
    int          tick_cyc[$];
    logic [13:0] addrs[$];
    logic [13:0] exp_addrs[$] = '{14'd0, 14'd1, 14'd2, 14'd3};
    int          dones = 0;
    int          gap_cycles = 0;
    bus.trig = 4'b0001;
    tick_clk();
    checks++;
    if (bus.pending !== 4'b0001 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pending: pend=%b busy=%b, expected pend=0001 busy=0", bus.pending, bus.busy);
    end
    bus.trig = 4'b0000;
    tick_clk();
    checks++;
    if (bus.busy !== 1'b1 || bus.pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_load: busy=%b pend=%b, expected busy=1 pend=0000", bus.busy, bus.pending);
    end
    for (int i = 1; i <= 140; i++) begin
      tick_clk();
      if (bus.sample_tick === 1'b1) begin
        tick_cyc.push_back(i);
        addrs.push_back(bus.rom_addr);
      end
      if (bus.clip_done === 1'b1) begin
        dones++;
        checks++;
        if (addrs.size() != 4 || bus.sample_tick !== 1'b1) begin
          errors++;
          $display("[TB] FAIL single_done_position: done at tick %0d, expected on tick 4", addrs.size());
        end
      end
      if (dones > 0 && bus.busy === 1'b1 && bus.play_en === 1'b0) gap_cycles++;
      checks++;
      if (bus.rom_addr !== model_addr() || bus.play_en !== exp_play()) begin
        errors++;
        $display("[TB] FAIL single_cycle %0d: addr=%0d play=%b, expected addr=%0d play=%b",
                 i, bus.rom_addr, bus.play_en, model_addr(), exp_play());
      end
    end
    checks++;
    if (addrs.size() != 4) begin
      errors++;
      $display("[TB] FAIL single_tick_count: got %0d expected 4", addrs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (addrs[k] !== exp_addrs[k] || tick_cyc[k] != DIV * (k + 1)) begin
          errors++;
          $display("[TB] FAIL single_tick %0d: addr=%0d at cycle %0d, expected addr=%0d at cycle %0d",
                   k, addrs[k], tick_cyc[k], exp_addrs[k], DIV * (k + 1));
        end
      end
    end
    checks++;
    if (dones != 1 || gap_cycles != GAP || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_end: dones=%0d gap=%0d busy=%b, expected dones=1 gap=%0d busy=0",
               dones, gap_cycles, bus.busy, GAP);
    end
  endtask

  task automatic test_priority();
    logic [13:0] addrs[$];
    int          clips[$];
    logic [13:0] exp_addrs[$] = '{14'd4096, 14'd4097, 14'd4098, 14'd8192};
    int          exp_clips[$] = '{1, 1, 1, 2};
    bus.trig = 4'b0110;
    tick_clk();
    checks++;
    if (bus.pending !== 4'b0110) begin
      errors++;
      $display("[TB] FAIL prio_pending: got %b expected 0110", bus.pending);
    end
    bus.trig = 4'b0000;
    tick_clk();
    checks++;
    if (bus.active_clip !== 2'd1 || bus.pending !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL prio_grant: clip=%0d pend=%b, expected clip=1 pend=0100", bus.active_clip, bus.pending);
    end
    for (int i = 1; i <= 160; i++) begin
      tick_clk();
      if (bus.sample_tick === 1'b1) begin
        addrs.push_back(bus.rom_addr);
        clips.push_back(int'(bus.active_clip));
      end
      if (bus.play_en === 1'b1 && bus.active_clip === 2'd1) begin
        checks++;
        if (bus.pending !== 4'b0100) begin
          errors++;
          $display("[TB] FAIL prio_pending_during cycle %0d: got %b expected 0100", i, bus.pending);
        end
      end
    end
    checks++;
    if (addrs.size() != 4) begin
      errors++;
      $display("[TB] FAIL prio_tick_count: got %0d expected 4", addrs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (addrs[k] !== exp_addrs[k] || clips[k] != exp_clips[k]) begin
          errors++;
          $display("[TB] FAIL prio_tick %0d: addr=%0d clip=%0d, expected addr=%0d clip=%0d",
                   k, addrs[k], clips[k], exp_addrs[k], exp_clips[k]);
        end
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.pending !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL prio_end: busy=%b pend=%b, expected busy=0 pend=0000", bus.busy, bus.pending);
    end
  endtask

  task automatic test_wrap();
    logic [13:0] addrs[$];
    logic [13:0] exp_addrs[$] = '{14'd16382, 14'd16383, 14'd0, 14'd1};
    bus.trig = 4'b1000;
    tick_clk();
    bus.trig = 4'b0000;
    for (int i = 0; i < 130; i++) begin
      tick_clk();
      if (bus.sample_tick === 1'b1) addrs.push_back(bus.rom_addr);
    end
    checks++;
    if (addrs.size() != 4) begin
      errors++;
      $display("[TB] FAIL wrap_tick_count: got %0d expected 4", addrs.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (addrs[k] !== exp_addrs[k]) begin
          errors++;
          $display("[TB] FAIL wrap_addr %0d: got %0d expected %0d", k, addrs[k], exp_addrs[k]);
        end
      end
    end
  endtask

  task automatic test_stop();
    int dones = 0;
    bus.trig = 4'b0001;
    tick_clk();
    bus.trig = 4'b0000;
    tick_clk();
    for (int i = 0; i < 40; i++) begin
      tick_clk();
      if (bus.clip_done === 1'b1) dones++;
    end
    bus.trig = 4'b1000;
    tick_clk();
    checks++;
    if (bus.pending !== 4'b1000 || bus.play_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stop_setup: pend=%b play=%b, expected pend=1000 play=1", bus.pending, bus.play_en);
    end
    bus.stop = 1'b1;
    tick_clk();
    checks++;
    if (bus.busy !== 1'b0 || bus.pending !== 4'b0000 || bus.play_en !== 1'b0 || bus.clip_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stop_effect: busy=%b pend=%b play=%b done=%b, expected all zero",
               bus.busy, bus.pending, bus.play_en, bus.clip_done);
    end
    bus.stop = 1'b0;
    bus.trig = 4'b0000;
    for (int i = 0; i < 30; i++) begin
      tick_clk();
      if (bus.clip_done === 1'b1) dones++;
      checks++;
      if (bus.busy !== 1'b0 || bus.sample_tick !== 1'b0 || bus.rom_addr !== model_addr()) begin
        errors++;
        $display("[TB] FAIL stop_idle cycle %0d: busy=%b tick=%b addr=%0d, expected busy=0 tick=0 addr=%0d",
                 i, bus.busy, bus.sample_tick, bus.rom_addr, model_addr());
      end
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("[TB] FAIL stop_no_done: got %0d clip_done pulses expected 0", dones);
    end
  endtask

  task automatic test_loop_enable();
    int ticks = 0;
    int dones = 0;
    int first_resume = -1;
    bus.loop = 1'b1;
    bus.trig = 4'b0001;
    tick_clk();
    bus.trig = 4'b0000;
    tick_clk();
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 1; i <= 130; i++) begin
        tick_clk();
        if (bus.sample_tick === 1'b1) begin
          if (phase == 1 && first_resume < 0) first_resume = i;
          checks++;
          if (bus.rom_addr !== 14'(ticks % 4) || bus.clip_done !== (ticks % 4 == 3)) begin
            errors++;
            $display("[TB] FAIL loop_tick %0d: addr=%0d done=%b, expected addr=%0d done=%b",
                     ticks, bus.rom_addr, bus.clip_done, ticks % 4, ticks % 4 == 3);
          end
          ticks++;
        end
        if (bus.clip_done === 1'b1) dones++;
        checks++;
        if (bus.rom_addr !== model_addr()) begin
          errors++;
          $display("[TB] FAIL loop_addr phase %0d cycle %0d: got %0d expected %0d",
                   phase, i, bus.rom_addr, model_addr());
        end
      end
      if (phase == 0) begin
        bus.enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
          tick_clk();
          checks++;
          if (bus.rom_addr !== 14'd1 || bus.sample_tick !== 1'b0 || bus.play_en !== 1'b0 ||
              bus.clip_done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL freeze cycle %0d: addr=%0d tick=%b play=%b done=%b busy=%b, expected addr=1 tick=0 play=0 done=0 busy=1",
                     i, bus.rom_addr, bus.sample_tick, bus.play_en, bus.clip_done, bus.busy);
          end
        end
        bus.enable = 1'b1;
      end
    end
    checks++;
    if (ticks != 10 || dones != 2 || first_resume != 20) begin
      errors++;
      $display("[TB] FAIL loop_summary: ticks=%0d dones=%0d resume_tick=%0d, expected ticks=10 dones=2 resume_tick=20",
               ticks, dones, first_resume);
    end
    bus.loop = 1'b0;
    bus.stop = 1'b1;
    tick_clk();
    bus.stop = 1'b0;
    tick_clk();
  endtask

  task automatic test_random();
    rst = 1'b1;
    bus.trig = '0; bus.stop = 1'b0; bus.loop = 1'b0; bus.enable = 1'b1;
    repeat (2) tick_clk();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 40) == 0) bus.trig[b] = ~bus.trig[b];
      end
      bus.stop   = ($urandom_range(0, 300) == 0);
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 150) == 0) bus.loop = ~bus.loop;
      tick_clk();
      checks++;
      if (bus.rom_addr !== model_addr()) begin
        errors++;
        $display("[TB] FAIL rand_addr cycle %0d: got %0d expected %0d", i, bus.rom_addr, model_addr());
      end
      checks++;
      if (bus.sample_tick !== exp_tick() || bus.clip_done !== exp_done() || bus.play_en !== exp_play()) begin
        errors++;
        $display("[TB] FAIL rand_strobes cycle %0d: tick=%b done=%b play=%b, expected tick=%b done=%b play=%b",
                 i, bus.sample_tick, bus.clip_done, bus.play_en, exp_tick(), exp_done(), exp_play());
      end
      checks++;
      if (bus.busy !== m_busy || bus.pending !== m_pend || bus.active_clip !== 2'(m_clip)) begin
        errors++;
        $display("[TB] FAIL rand_status cycle %0d: busy=%b pend=%b clip=%0d, expected busy=%b pend=%b clip=%0d",
                 i, bus.busy, bus.pending, bus.active_clip, m_busy, m_pend, m_clip);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_clip();
    test_priority();
    test_wrap();
    test_stop();
    test_loop_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
